sonar_echo_logger: RTL
======================

# sonar_echo_logger

Downstream consumer of the sonar datapath's per-sample detection result. Each time the moving-average envelope crosses the threshold, the block timestamps the echo in PCM-sample ticks since the last master clear. It tracks the peak envelope amplitude for the duration of the echo. On echo end it pushes a {timestamp, peak} record into a small FIFO. Firmware drains the FIFO over the same 16-bit register-style Wishbone slave used by the rest of the design, so several echoes per ping are captured instead of only the first latched one.

## Interface
Parameters:
- FIFO_DEPTH, 8: record slots; power of two, 2..16.
- HOLDOFF_RST, 16'd8: reset value of the HOLDOFF register, in PCM ticks.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
- wb_valid_i  in  1  bus request.
- wbs_adr_i  in  2  register address.
- wbs_dat_i  in  16  write data.
- wbs_strb_i  in  1  1 = write, 0 = read.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  16  registered read data.
- ce_pcm  in  1  PCM sample tick (same strobe driving the datapath).
- mclear  in  1  start of ping / master clear.
- det_i  in  1  unlatched comparator output (envelope > threshold).
- env_i  in  16  unsigned moving-average envelope, valid on ce_pcm.
- irq_o  out  1  only with ECHO_LOG_IRQ_EN; see Configuration.

## Operation
- Registers:
  - 0 STATUS, R: [4:0] count, [5] empty, [6] full, [7] overflow (sticky), [9:8] state. Writing 1 to bit 7 clears overflow.
  - 1 HEAD_TS, R: head timestamp. Does not pop.
  - 2 HEAD_PEAK, R: head peak, then pops. Reading it when empty returns 0 and does not pop. Writes are ignored.
  - 3 HOLDOFF, RW.
- Tick counter: 16 bits. Cleared by mclear. Increments on ce_pcm in ARMED, ECHO and HOLD. Saturates at 16'hFFFF.
- FSM states: IDLE=0, ARMED=1, ECHO=2, HOLD=3. det_i and env_i are sampled only on ce_pcm cycles.
  - IDLE: wait for mclear.
  - ARMED, det_i=1: ts <= counter, peak <= env_i, go to ECHO.
  - ECHO, det_i=1: peak <= max(peak, env_i), unsigned compare.
  - ECHO, det_i=0: push {ts, peak}, load the holdoff counter with HOLDOFF. Go to HOLD, or directly to ARMED if HOLDOFF=0.
  - HOLD: det_i is ignored. Decrement per tick; go to ARMED on the tick where the holdoff counter reaches 0. HOLD therefore lasts exactly HOLDOFF ticks.
  - Counter saturated on a tick: ECHO pushes its record then goes to IDLE; ARMED and HOLD go to IDLE.
- mclear, from any state: go to ARMED, counter 0, FIFO flushed, overflow cleared. mclear has priority over ce_pcm in the same cycle.
- Full on push: record dropped, overflow set. If a pop and a push occur in the same cycle, the pop is applied first and the push is accepted.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, state IDLE, FIFO empty, overflow 0, HOLDOFF=HOLDOFF_RST.
- Bus transaction: a cycle with wb_valid_i=1 and wbs_ack_o=0.
  - wbs_ack_o and wbs_dat_o are valid on the following cycle.
  - If valid is held high, acks come every other cycle and only one pop occurs per transaction.
  - The write takes effect at the ack edge.
- Pop latency: a HEAD_PEAK read returns the pre-pop head. The new head is visible on the next transaction.
- Record latency: pushed on the clock edge of the ce_pcm cycle where det_i=0 is seen in ECHO. STATUS.count reflects it one cycle later.
- ts equals the counter value on the tick where det_i was first seen high. The first tick after mclear has ts=0.
- Reset applied mid-echo discards the in-progress echo and all FIFO contents.

## Configuration
- ECHO_LOG_IRQ_EN defined: irq_o port exists.
  - irq_o is a registered level: (!empty) | overflow.
  - It rises one cycle after the causing push or overflow event.
  - It falls one cycle after the FIFO empties and overflow is cleared.
- ECHO_LOG_IRQ_EN undefined: no irq_o port and no logic; firmware polls STATUS.

## Test plan
- Reset, then read STATUS -> 16'h0020 (empty, IDLE). Read HOLDOFF -> 16'd8.
- mclear; det_i high on ticks 5..7 with env 100, 300, 200 -> one record; HEAD_TS=5, HEAD_PEAK=300, then STATUS empty.
- HOLDOFF=3; echo ends at tick 10; det_i pulses on ticks 11..13 and at 14 -> only the tick-14 pulse is recorded, ts=14.
- FIFO_DEPTH+1 echoes without reads -> count=FIFO_DEPTH, full=1, overflow=1. The first record is intact. Write 16'h0080 to STATUS -> overflow=0.
- mclear asserted during ECHO with 3 records stored -> count=0, state ARMED, counter restarts at 0. wb_rst_ni low mid-echo -> all reset values.
- With ECHO_LOG_IRQ_EN: a push raises irq_o one cycle later; draining the last record drops irq_o. Counter run to 16'hFFFF while in ECHO -> record pushed, state IDLE.

Source files
------------

// File: rtl/sonar_echo_logger.sv
// sonar_echo_logger: timestamps threshold-crossing echoes in PCM ticks,
// tracks the peak envelope for each echo, and queues {ts, peak} records
// in a small FIFO that firmware drains over a 16-bit register slave.
// Optional build macro: ECHO_LOG_IRQ_EN adds the irq_o level output.
module sonar_echo_logger #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] HOLDOFF_RST = 16'd8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_valid_i,
    input  logic [1:0]  wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    input  logic        wbs_strb_i,
    output logic        wbs_ack_o,
    output logic [15:0] wbs_dat_o,
    input  logic        ce_pcm,
    input  logic        mclear,
    input  logic        det_i,
    input  logic [15:0] env_i
`ifdef ECHO_LOG_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ECHO  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Echo tracking state
    state_t        state_reg;
    logic [15:0]   tick_reg;
    logic [15:0]   ts_reg;
    logic [15:0]   peak_reg;
    logic [15:0]   hold_reg;

    // Register file and bus outputs
    logic [15:0]   holdoff_reg;
    logic          ack_reg;
    logic [15:0]   dat_reg;

    // Record FIFO: upper half timestamp, lower half peak
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    // Combinational helpers
    logic          bus_req;
    logic          rd_req;
    logic          wr_req;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          sat;
    logic          echo_end;
    logic [15:0]   peak_max;
    logic [31:0]   push_data;
    logic          push_accept;
    logic          push_drop;
    logic [31:0]   head;
    logic [15:0]   rd_data;

    // Bus decode, FIFO flags and the push request raised when an echo ends
    always_comb begin
        bus_req     = wb_valid_i && !ack_reg;
        rd_req      = bus_req && !wbs_strb_i;
        wr_req      = bus_req && wbs_strb_i;
        fifo_empty  = (count_reg == '0);
        fifo_full   = (count_reg == CW'(FIFO_DEPTH));
        // mclear flushes the FIFO, so a simultaneous pop is meaningless
        pop         = rd_req && (wbs_adr_i == 2'd2) && !fifo_empty && !mclear;
        sat         = (tick_reg == 16'hFFFF);
        echo_end    = ce_pcm && !mclear && (state_reg == ECHO) && (!det_i || sat);
        peak_max    = (env_i > peak_reg) ? env_i : peak_reg;
        // On a saturation tick with det_i still high the current sample counts
        push_data   = {ts_reg, (det_i ? peak_max : peak_reg)};
        // Pop is applied first, so a full FIFO being popped still accepts
        push_accept = echo_end && (!fifo_full || pop);
        push_drop   = echo_end && fifo_full && !pop;
        head        = mem[rd_ptr_reg];
    end

    // Register read multiplexer; head fields read as 0 when nothing is queued
    always_comb begin
        rd_data = '0;
        case (wbs_adr_i)
            2'd0: rd_data = {6'd0, state_reg, overflow_reg, fifo_full, fifo_empty, 5'(count_reg)};
            2'd1: rd_data = fifo_empty ? 16'd0 : head[31:16];
            2'd2: rd_data = fifo_empty ? 16'd0 : head[15:0];
            2'd3: rd_data = holdoff_reg;
            default: rd_data = '0;
        endcase
    end

    // Bus slave: one-cycle ack, registered read data, HOLDOFF writes
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            holdoff_reg <= HOLDOFF_RST;
        end else begin
            ack_reg <= bus_req;
            if (rd_req) begin
                dat_reg <= rd_data;
            end
            if (wr_req && (wbs_adr_i == 2'd3)) begin
                holdoff_reg <= wbs_dat_i;
            end
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;

    // Record storage, left unreset so it maps onto plain RAM
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && push_accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (mclear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_accept) - CW'(pop);
            // A new drop wins over a same-cycle clear so the event is not lost
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end else if (wr_req && (wbs_adr_i == 2'd0) && wbs_dat_i[7]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Echo FSM with tick counter; inputs are only looked at on ce_pcm
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            ts_reg    <= '0;
            peak_reg  <= '0;
            hold_reg  <= '0;
        end else if (mclear) begin
            state_reg <= ARMED;
            tick_reg  <= '0;
        end else if (ce_pcm) begin
            if ((state_reg != IDLE) && !sat) begin
                tick_reg <= tick_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    state_reg <= IDLE;
                end
                ARMED: begin
                    if (sat) begin
                        state_reg <= IDLE;
                    end else if (det_i) begin
                        ts_reg    <= tick_reg;
                        peak_reg  <= env_i;
                        state_reg <= ECHO;
                    end
                end
                ECHO: begin
                    if (sat) begin
                        state_reg <= IDLE;
                    end else if (det_i) begin
                        peak_reg <= peak_max;
                    end else begin
                        hold_reg  <= holdoff_reg;
                        state_reg <= (holdoff_reg == 16'd0) ? ARMED : HOLD;
                    end
                end
                HOLD: begin
                    if (sat) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_reg <= hold_reg - 16'd1;
                        if (hold_reg == 16'd1) begin
                            state_reg <= ARMED;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ECHO_LOG_IRQ_EN
    logic irq_reg;

    // Interrupt level: records pending or a record was dropped
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= !fifo_empty || overflow_reg;
        end
    end

    assign irq_o = irq_reg;
`endif

endmodule
